// File: rtl/led_seq_pkg.sv
// Shared mode and direction encodings for the LED sequencer.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ROL    = 2'b00,
      MODE_ROR    = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_COUNT  = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/led_sequencer_tick_divider.sv
// Free-running clock divider producing a registered one-cycle step tick.
module tick_divider #(
   parameter int DIV = 10
) (
   input  logic CLK_12MHz,
   input  logic RST,
   output logic TICK
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // TICK is raised one edge early so it is high during the wrap cycle,
   // letting the consumer act on the same edge the counter wraps.
   always_ff @(posedge CLK_12MHz or posedge RST) begin
      if (RST) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == PRE);
      end
   end

   assign TICK = r_tick;

endmodule

// File: rtl/led_sequencer.sv
// LED pattern engine: synchronised switch/mode inputs, step divider and
// a per-step pattern update with override and restart handling.
import led_seq_pkg::*;

module led_sequencer #(
   parameter int WIDTH   = 8,
   parameter int CLK_HZ  = 12000000,
   parameter int STEP_HZ = 20
) (
   input  logic             CLK_12MHz,
   input  logic             RST,
   input  logic             MYSWITCH,
   input  logic [1:0]       MODE,
   output logic [WIDTH-1:0] LED,
   output logic             STEP
);

   localparam int DIV = CLK_HZ / STEP_HZ;
   localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

   logic             w_tick;
   logic             r_sw_meta, r_sw_sync;
   logic [1:0]       r_mode_meta, r_mode_sync;
   logic [1:0]       r_mode_lat;
   logic             r_ovr;
   dir_e             r_dir;
   logic [WIDTH-1:0] r_led;
   logic             r_step;

   tick_divider #(.DIV(DIV)) u_div (
      .CLK_12MHz (CLK_12MHz),
      .RST       (RST),
      .TICK      (w_tick)
   );

   function automatic logic [WIDTH-1:0] init_led(input logic [1:0] m);
      case (m)
         MODE_ROR:   init_led = LED_MSB;
         MODE_COUNT: init_led = '0;
         default:    init_led = LED_ONE;
      endcase
   endfunction

   always_ff @(posedge CLK_12MHz or posedge RST) begin
      if (RST) begin
         r_sw_meta   <= 1'b1;
         r_sw_sync   <= 1'b1;
         r_mode_meta <= MODE_ROL;
         r_mode_sync <= MODE_ROL;
         r_mode_lat  <= MODE_ROL;
         r_ovr       <= 1'b0;
         r_dir       <= DIR_UP;
         r_led       <= LED_ONE;
         r_step      <= 1'b0;
      end else begin
         r_sw_meta   <= MYSWITCH;
         r_sw_sync   <= r_sw_meta;
         r_mode_meta <= MODE;
         r_mode_sync <= r_mode_meta;
         r_step      <= w_tick;
         if (w_tick) begin
            if (!r_sw_sync) begin
               r_led <= '1;
               r_ovr <= 1'b1;
            end else if (r_ovr || (r_mode_sync != r_mode_lat)) begin
               // Leaving override or a new mode both restart the pattern cleanly.
               r_mode_lat <= r_mode_sync;
               r_ovr      <= 1'b0;
               r_dir      <= DIR_UP;
               r_led      <= init_led(r_mode_sync);
            end else begin
               case (r_mode_lat)
                  MODE_ROL: r_led <= {r_led[WIDTH-2:0], r_led[WIDTH-1]};
                  MODE_ROR: r_led <= {r_led[0], r_led[WIDTH-1:1]};
                  MODE_BOUNCE: begin
                     // Turn around at an endpoint so each end is shown for one step only.
                     if (r_dir == DIR_UP) begin
                        if (r_led[WIDTH-1]) begin
                           r_led <= r_led >> 1;
                           r_dir <= DIR_DOWN;
                        end else begin
                           r_led <= r_led << 1;
                        end
                     end else begin
                        if (r_led[0]) begin
                           r_led <= r_led << 1;
                           r_dir <= DIR_UP;
                        end else begin
                           r_led <= r_led >> 1;
                        end
                     end
                  end
                  default: r_led <= r_led + 1'b1;
               endcase
            end
         end
      end
   end

   assign LED  = r_led;
   assign STEP = r_step;

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised check of led_sequencer against a step-count/phase based model.
module tb_led_sequencer;

   localparam int W    = 4;
   localparam int DIV  = 10;
   localparam int P    = 2 * (W - 1);
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sw  = 1'b1;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] led;
   logic         step;

   int checks   = 0;
   int failures = 0;

   led_sequencer #(.WIDTH(W), .CLK_HZ(100), .STEP_HZ(10)) dut (
      .CLK_12MHz (clk),
      .RST       (rst),
      .MYSWITCH  (sw),
      .MODE      (mode),
      .LED       (led),
      .STEP      (step)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned  ecnt;
   logic [W-1:0] m_led;
   logic         m_step;
   logic [1:0]   m_lat;
   logic         m_flag;
   int           bk;
   logic [1:0]   swh;
   logic [1:0][1:0] mh;

   function automatic logic [W-1:0] m_init(input int md);
      if (md == 1) return W'(1 << (W - 1));
      if (md == 3) return '0;
      return W'(1);
   endfunction

   function automatic logic [W-1:0] m_adv(input int md, input int v, input int nbk);
      case (md)
         0: return W'(((v << 1) | (v >> (W - 1))) & MASK);
         1: return W'(((v >> 1) | (v << (W - 1))) & MASK);
         2: return W'(1 << ((nbk < W) ? nbk : P - nbk));
         default: return W'((v + 1) & MASK);
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ecnt   <= 0;
         m_led  <= W'(1);
         m_step <= 1'b0;
         m_lat  <= 2'b00;
         m_flag <= 1'b0;
         bk     <= 0;
         swh    <= 2'b11;
         mh     <= '0;
      end else begin
         swh    <= {swh[0], sw};
         mh     <= {mh[0], mode};
         ecnt   <= ecnt + 1;
         m_step <= ((ecnt + 1) % DIV == 0);
         if ((ecnt + 1) % DIV == 0) begin
            if (!swh[1]) begin
               m_led  <= W'(MASK);
               m_flag <= 1'b1;
            end else if (m_flag || mh[1] != m_lat) begin
               m_lat  <= mh[1];
               m_flag <= 1'b0;
               bk     <= 0;
               m_led  <= m_init(int'(mh[1]));
            end else begin
               bk    <= (bk + 1) % P;
               m_led <= m_adv(int'(m_lat), int'(m_led), (bk + 1) % P);
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("led_vs_model", int'(led), int'(m_led));
      chk("step_vs_model", int'(step), int'(m_step));
   end

   // ---------------- stimulus ----------------
   task automatic wait_step(input string name);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (step) seen = 1;
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int n;
      bit found;
      repeat (3) @(negedge clk);
      chk("reset_led", int'(led), 1);
      chk("reset_step", int'(step), 0);
      #2 rst = 1'b0;

      repeat (9) @(negedge clk);
      chk("pre_first_step", int'(step), 0);
      chk("pre_first_led", int'(led), 1);
      @(negedge clk);
      chk("first_step", int'(step), 1);
      chk("first_led", int'(led), 2);
      repeat (40) @(negedge clk);

      mode = 2'b10;
      repeat (120) @(negedge clk);
      mode = 2'b11;
      repeat (180) @(negedge clk);
      mode = 2'b01;
      repeat (60) @(negedge clk);
      sw = 1'b0;
      repeat (25) @(negedge clk);
      sw = 1'b1;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 250; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) mode = 2'($urandom_range(0, 3));
         else if (r < 5) sw = ~sw;
         repeat ($urandom_range(1, 35)) @(negedge clk);
      end
      sw = 1'b1;
      mode = 2'b00;
      repeat (40) @(negedge clk);

      // Override and mode change landing together.
      wait_step("t5_a");
      sw = 1'b0;
      mode = 2'b01;
      wait_step("t5_b");
      chk("override_led", int'(led), 15);
      sw = 1'b1;
      wait_step("t5_c");
      chk("release_led", int'(led), 8);

      // Mid-pattern reset with LED = 4 in rotate-left.
      mode = 2'b00;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         wait_step("t6_a");
         if (led == 4 && mode == 2'b00) found = 1;
      end
      chk("t6_found_led4", int'(found), 1);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_led", int'(led), 1);
      chk("midreset_step", int'(step), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      n = 0;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(posedge clk);
         n++;
         #1;
         if (step) found = 1;
      end
      chk("post_reset_step_edges", n, 10);
      chk("post_reset_led", int'(led), 2);
      repeat (20) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
